regfile_sb: RTL and testbench

- Clocked, parametrised successor of the single-cycle MIPS register file.
- Provides two read ports and one write port, with register 0 hardwired to zero.
- Adds a reset-driven clear sweep and a per-register busy scoreboard, which the pipelined datapath uses for RAW hazard detection.
- Sits between decode (reads, busy set) and writeback (write, busy clear).

---
 rtl/regfile_sb.sv | 115 +++++++++++
 tb/tb_regfile_sb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Two-read / one-write register file with r0 hardwired to zero, a clear sweep after reset,
// and a per-register busy scoreboard. Define REGFILE_WRITE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              RegWrite,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_reg,
  output logic              busy1,
  output logic              busy2,
  output logic              ready
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_busy;
  logic              w_run;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= CLEAR;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CLEAR:   if (r_cnt == '1) w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = CLEAR;
    endcase
  end

  // The sweep and architectural writes share the single memory write port.
  always_comb begin
    w_run   = (r_state == RUN);
    ready   = w_run;
    w_we    = 1'b0;
    w_waddr = r_cnt;
    w_wdata = '0;
    if (r_state == CLEAR) begin
      w_we = 1'b1;
    end else if (RegWrite && (write_reg != '0)) begin
      w_we    = 1'b1;
      w_waddr = write_reg;
      w_wdata = write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                     r_cnt <= '0;
    else if (r_state == CLEAR)   r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && w_we) r_mem[w_waddr] <= w_wdata;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
    if (gi == 0) begin : g_zero
      assign w_busy[gi] = 1'b0;
    end else begin : g_bit
      logic r_bit;
      // A new producer supersedes a retiring one, so set takes priority over clear.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_bit <= 1'b0;
        end else if (w_run) begin
          if (busy_set && (busy_reg == ADDR_W'(gi)))       r_bit <= 1'b1;
          else if (RegWrite && (write_reg == ADDR_W'(gi))) r_bit <= 1'b0;
        end
      end
      assign w_busy[gi] = r_bit;
    end
  end

  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    busy1      = 1'b0;
    busy2      = 1'b0;
    if (w_run) begin
      read_data1 = (read_reg1 == '0) ? '0 : r_mem[read_reg1];
      read_data2 = (read_reg2 == '0) ? '0 : r_mem[read_reg2];
      busy1      = w_busy[read_reg1];
      busy2      = w_busy[read_reg2];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (w_we && (write_reg == read_reg1)) begin
        read_data1 = write_data;
        busy1      = 1'b0;
      end
      if (w_we && (write_reg == read_reg2)) begin
        read_data2 = write_data;
        busy2      = 1'b0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_regfile_sb;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2 ** ADDR_W;
`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic [ADDR_W-1:0] read_reg1 = '0, read_reg2 = '0, write_reg = '0, busy_reg = '0;
  logic [DATA_W-1:0] write_data = '0;
  logic              RegWrite = 1'b0, busy_set = 1'b0;
  logic [DATA_W-1:0] read_data1, read_data2;
  logic              busy1, busy2, ready;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2),
    .write_reg(write_reg), .write_data(write_data), .RegWrite(RegWrite),
    .busy_set(busy_set), .busy_reg(busy_reg),
    .busy1(busy1), .busy2(busy2), .ready(ready)
  );

  // Small-parameter instance
  logic        p_rst = 1'b1;
  logic [2:0]  p_rr1 = '0, p_rr2 = '0, p_wr = '0, p_br = '0;
  logic [15:0] p_wd = '0;
  logic        p_we = 1'b0, p_bs = 1'b0;
  logic [15:0] p_rd1, p_rd2;
  logic        p_b1, p_b2, p_ready;

  regfile_sb #(.DATA_W(16), .ADDR_W(3)) dut_small (
    .clk(clk), .rst(p_rst),
    .read_reg1(p_rr1), .read_reg2(p_rr2),
    .read_data1(p_rd1), .read_data2(p_rd2),
    .write_reg(p_wr), .write_data(p_wd), .RegWrite(p_we),
    .busy_set(p_bs), .busy_reg(p_br),
    .busy1(p_b1), .busy2(p_b2), .ready(p_ready)
  );

  typedef struct {
    int                tag;
    logic              rdy;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              b1;
    logic              b2;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   tag_cnt  = 0;

  // Reference model: contents are simply zero after reset; ready follows a count of released cycles.
  logic [DATA_W-1:0] m_mem  [DEPTH];
  bit                m_busy [DEPTH];
  int                m_since = 0;
  bit                m_valid = 1'b0;

  task automatic chk(input string name, input int tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s txn=%0d actual=%h required=%h", name, tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ready", e.tag, DATA_W'(ready), DATA_W'(e.rdy));
      chk("read_data1", e.tag, read_data1, e.rd1);
      chk("read_data2", e.tag, read_data2, e.rd2);
      chk("busy1", e.tag, DATA_W'(busy1), DATA_W'(e.b1));
      chk("busy2", e.tag, DATA_W'(busy2), DATA_W'(e.b2));
      $display("txn %0d rdy=%0b rd1=%h rd2=%h b1=%0b b2=%0b", e.tag, ready, read_data1, read_data2, busy1, busy2);
    end
  end

  function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] r, input logic [ADDR_W-1:0] wr,
                                               input logic [DATA_W-1:0] wd, input bit we);
    if (m_since < DEPTH) return '0;
    if (BYPASS && we && wr != 0 && wr == r) return wd;
    if (r == 0) return '0;
    return m_mem[r];
  endfunction

  function automatic logic m_bsy(input logic [ADDR_W-1:0] r, input logic [ADDR_W-1:0] wr, input bit we);
    if (m_since < DEPTH) return 1'b0;
    if (BYPASS && we && wr != 0 && wr == r) return 1'b0;
    return m_busy[r];
  endfunction

  task automatic step(input bit rs, input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2,
                      input logic [ADDR_W-1:0] wr, input logic [DATA_W-1:0] wd, input bit we,
                      input bit bs, input logic [ADDR_W-1:0] br);
    rst = rs; read_reg1 = r1; read_reg2 = r2; write_reg = wr;
    write_data = wd; RegWrite = we; busy_set = bs; busy_reg = br;
    if (m_valid) begin
      exp_t e;
      e.tag = tag_cnt++;
      e.rdy = (m_since >= DEPTH);
      e.rd1 = m_read(r1, wr, wd, we);
      e.rd2 = m_read(r2, wr, wd, we);
      e.b1  = m_bsy(r1, wr, we);
      e.b2  = m_bsy(r2, wr, we);
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (rs) begin
      m_valid = 1'b1;
      m_since = 0;
      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    end else if (m_valid) begin
      if (m_since < DEPTH) begin
        m_since++;
      end else begin
        if (we && wr != 0) begin m_mem[wr] = wd; m_busy[wr] = 1'b0; end
        if (bs && br != 0) m_busy[br] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input logic [ADDR_W-1:0] r1);
    for (int i = 0; i < n; i++) step(1'b0, r1, '0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Reset and sweep
    step(1'b1, 5'd7, '0, '0, '0, 1'b0, 1'b0, '0);
    step(1'b1, 5'd7, '0, '0, '0, 1'b0, 1'b0, '0);
    idle(DEPTH + 3, 5'd7);
    // Write/read, r0 write discarded
    step(1'b0, '0, '0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, '0);
    step(1'b0, '0, 5'd5, '0, '0, 1'b0, 1'b0, '0);
    step(1'b0, '0, '0, 5'd0, 32'h12345678, 1'b1, 1'b0, '0);
    step(1'b0, 5'd0, 5'd5, '0, '0, 1'b0, 1'b0, '0);
    // Scoreboard set / same-cycle set+clear / later clear
    step(1'b0, 5'd9, '0, '0, '0, 1'b0, 1'b1, 5'd9);
    step(1'b0, 5'd9, '0, '0, '0, 1'b0, 1'b0, '0);
    step(1'b0, 5'd9, '0, 5'd9, 32'h11111111, 1'b1, 1'b1, 5'd9);
    step(1'b0, 5'd9, '0, '0, '0, 1'b0, 1'b0, '0);
    step(1'b0, 5'd9, '0, 5'd9, 32'h22222222, 1'b1, 1'b0, '0);
    step(1'b0, 5'd9, 5'd9, '0, '0, 1'b0, 1'b0, '0);
    // Write while reading the same register
    step(1'b0, 5'd3, 5'd3, 5'd3, 32'hA5A5A5A5, 1'b1, 1'b0, '0);
    step(1'b0, 5'd3, '0, '0, '0, 1'b0, 1'b0, '0);
    // Reset during RUN
    step(1'b0, 5'd4, '0, 5'd4, 32'h55, 1'b1, 1'b1, 5'd4);
    step(1'b0, 5'd4, 5'd4, '0, '0, 1'b0, 1'b0, '0);
    step(1'b1, 5'd4, 5'd4, '0, '0, 1'b0, 1'b0, '0);
    idle(DEPTH + 2, 5'd4);
    // Reset re-asserted at sweep step 10
    step(1'b1, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    idle(10, 5'd1);
    step(1'b1, '0, '0, '0, '0, 1'b0, 1'b0, '0);
    idle(DEPTH + 2, 5'd1);
    // Randomised traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      logic [ADDR_W-1:0] wr, r1, r2, br;
      wr = ADDR_W'($urandom);
      r1 = ($urandom_range(0, 3) == 0) ? wr : ADDR_W'($urandom);
      r2 = ($urandom_range(0, 3) == 0) ? wr : ADDR_W'($urandom);
      br = ($urandom_range(0, 3) == 0) ? wr : ADDR_W'($urandom);
      step($urandom_range(0, 199) == 0, r1, r2, wr, DATA_W'($urandom),
           1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, br);
    end
    idle(1, '0);
    @(negedge clk);
    #1;
    chk("queue_drained", 0, DATA_W'(exp_q.size()), '0);

    // Small instance: 8-cycle sweep and full-width write
    @(posedge clk); #1;
    p_rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    p_rst = 1'b0;
    n = 0;
    while (!p_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("small_sweep_len", 0, DATA_W'(n), DATA_W'(8));
    $display("small sweep cycles=%0d", n);
    p_wr = 3'd7; p_wd = 16'hFFFF; p_we = 1'b1; p_rr1 = 3'd7; p_rr2 = 3'd0;
    @(posedge clk); #1;
    p_we = 1'b0;
    chk("small_r7", 1, DATA_W'(p_rd1), DATA_W'(16'hFFFF));
    chk("small_r0", 2, DATA_W'(p_rd2), '0);
    $display("small read r7=%h r0=%h", p_rd1, p_rd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
